// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
// Signals: mem_req/mem_addr (fetch -> mem), mem_ack/mem_rdata (mem -> fetch).
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory read per fetch
// strobe and latches the returned word into the IR, decoded into fields.
// Ports: clk, rst (sync, active-high); ifu_ins_load/ifu_pc_inc/ifu_pc_load/
// ifu_pc_target from control; mem (master side of instr_fetch_unit_if);
// ifu_opcode/ifu_rd/ifu_rs1/ifu_rs2/ifu_pc/ifu_valid/ifu_busy to control.
// Build option: IFU_FETCH_TIMEOUT_EN adds a 16-cycle fetch timeout and the
// sticky ifu_fault output.
module instr_fetch_unit (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ifu_ins_load,
    input  logic                      ifu_pc_inc,
    input  logic                      ifu_pc_load,
    input  logic [7:0]                ifu_pc_target,
    instr_fetch_unit_if.master        mem,
    output logic [3:0]                ifu_opcode,
    output logic [3:0]                ifu_rd,
    output logic [3:0]                ifu_rs1,
    output logic [3:0]                ifu_rs2,
    output logic [7:0]                ifu_pc,
`ifdef IFU_FETCH_TIMEOUT_EN
    output logic                      ifu_fault,
`endif
    output logic                      ifu_valid,
    output logic                      ifu_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  addr_q, addr_d;
    logic        valid_q, valid_d;

`ifdef IFU_FETCH_TIMEOUT_EN
    logic [3:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
`ifdef IFU_FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        fault_d = fault_q;
`endif
        unique case (state_q)
            IDLE: begin
                // PC moves only here; a same-cycle fetch uses the old PC.
                if (ifu_pc_load)
                    pc_d = ifu_pc_target;
                else if (ifu_pc_inc)
                    pc_d = pc_q + 8'd1;
                if (ifu_ins_load) begin
                    addr_d  = pc_q;
                    state_d = REQ;
`ifdef IFU_FETCH_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end
            end
            REQ: begin
                // Control strobes are dropped here, not queued.
                if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
`ifdef IFU_FETCH_TIMEOUT_EN
                else if (cnt_q == 4'd15) begin
                    // Give up: hand control a NOP and flag the fault.
                    ir_d    = 16'h0000;
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 16'h0000;
            addr_q  <= 8'h00;
            valid_q <= 1'b0;
`ifdef IFU_FETCH_TIMEOUT_EN
            cnt_q   <= 4'd0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
`ifdef IFU_FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign ifu_busy     = (state_q == REQ);
    assign mem.mem_req  = ifu_busy;
    assign mem.mem_addr = addr_q;
    assign ifu_opcode   = ir_q[15:12];
    assign ifu_rd       = ir_q[11:8];
    assign ifu_rs1      = ir_q[7:4];
    assign ifu_rs2      = ir_q[3:0];
    assign ifu_pc       = pc_q;
    assign ifu_valid    = valid_q;
`ifdef IFU_FETCH_TIMEOUT_EN
    assign ifu_fault    = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst;
    logic       ifu_ins_load;
    logic       ifu_pc_inc;
    logic       ifu_pc_load;
    logic [7:0] ifu_pc_target;
    logic [3:0] ifu_opcode;
    logic [3:0] ifu_rd;
    logic [3:0] ifu_rs1;
    logic [3:0] ifu_rs2;
    logic [7:0] ifu_pc;
    logic       ifu_valid;
    logic       ifu_busy;
`ifdef IFU_FETCH_TIMEOUT_EN
    logic       ifu_fault;
`endif

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit_if mem_bus ();

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_ins_load  (ifu_ins_load),
        .ifu_pc_inc    (ifu_pc_inc),
        .ifu_pc_load   (ifu_pc_load),
        .ifu_pc_target (ifu_pc_target),
        .mem           (mem_bus),
        .ifu_opcode    (ifu_opcode),
        .ifu_rd        (ifu_rd),
        .ifu_rs1       (ifu_rs1),
        .ifu_rs2       (ifu_rs2),
        .ifu_pc        (ifu_pc),
`ifdef IFU_FETCH_TIMEOUT_EN
        .ifu_fault     (ifu_fault),
`endif
        .ifu_valid     (ifu_valid),
        .ifu_busy      (ifu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag, input logic [15:0] exp);
        check(tag, {16'h0, ifu_opcode, ifu_rd, ifu_rs1, ifu_rs2},
              {16'h0, exp});
    endtask

    initial begin
        rst                = 1'b1;
        ifu_ins_load       = 1'b0;
        ifu_pc_inc         = 1'b0;
        ifu_pc_load        = 1'b0;
        ifu_pc_target      = 8'h00;
        mem_bus.mem_ack    = 1'b0;
        mem_bus.mem_rdata  = 16'h0000;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_pc", 32'(ifu_pc), 32'h00);
        check_ir("rst_ir", 16'h0000);
        check("rst_req", 32'(mem_bus.mem_req), 32'h0);
        check("rst_valid", 32'(ifu_valid), 32'h0);
        check("rst_busy", 32'(ifu_busy), 32'h0);
`ifdef IFU_FETCH_TIMEOUT_EN
        check("rst_fault", 32'(ifu_fault), 32'h0);
`endif

        // basic fetch, zero-wait memory
        ifu_ins_load = 1'b1;
        tick();
        ifu_ins_load = 1'b0;
        check("bf_req", 32'(mem_bus.mem_req), 32'h1);
        check("bf_busy", 32'(ifu_busy), 32'h1);
        check("bf_addr", 32'(mem_bus.mem_addr), 32'h00);
        check("bf_novalid", 32'(ifu_valid), 32'h0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'h1234;
        tick();
        mem_bus.mem_ack   = 1'b0;
        check("bf_valid", 32'(ifu_valid), 32'h1);
        check_ir("bf_ir", 16'h1234);
        check("bf_req_drop", 32'(mem_bus.mem_req), 32'h0);
        tick();
        check("bf_valid_pulse", 32'(ifu_valid), 32'h0);
        check_ir("bf_hold", 16'h1234);

        // wait states: ack after 5 wait cycles, strobes ignored in REQ
        ifu_ins_load = 1'b1;
        tick();
        ifu_pc_inc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("ws_req", 32'(mem_bus.mem_req), 32'h1);
            check("ws_addr", 32'(mem_bus.mem_addr), 32'h00);
            tick();
        end
        check("ws_req6", 32'(mem_bus.mem_req), 32'h1);
        check("ws_addr6", 32'(mem_bus.mem_addr), 32'h00);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'hABCD;
        tick();
        ifu_ins_load    = 1'b0;
        ifu_pc_inc      = 1'b0;
        mem_bus.mem_ack = 1'b0;
        check("ws_valid", 32'(ifu_valid), 32'h1);
        check_ir("ws_ir", 16'hABCD);
        check("ws_pc", 32'(ifu_pc), 32'h00);
        check("ws_req_drop", 32'(mem_bus.mem_req), 32'h0);
        tick();

        // ack in IDLE is ignored
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'h5555;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("idle_ack_valid", 32'(ifu_valid), 32'h0);
        check_ir("idle_ack_ir", 16'hABCD);

        // PC wrap, load priority, fetch with simultaneous increment
        ifu_pc_load   = 1'b1;
        ifu_pc_target = 8'hFF;
        tick();
        check("pc_ld_ff", 32'(ifu_pc), 32'hFF);
        ifu_pc_load = 1'b0;
        ifu_pc_inc  = 1'b1;
        tick();
        check("pc_wrap", 32'(ifu_pc), 32'h00);
        ifu_pc_load   = 1'b1;
        ifu_pc_target = 8'h40;
        tick();
        check("pc_ld_prio", 32'(ifu_pc), 32'h40);
        ifu_pc_inc    = 1'b0;
        ifu_pc_target = 8'h10;
        tick();
        ifu_pc_load  = 1'b0;
        ifu_pc_inc   = 1'b1;
        ifu_ins_load = 1'b1;
        tick();
        ifu_pc_inc   = 1'b0;
        ifu_ins_load = 1'b0;
        check("fi_addr", 32'(mem_bus.mem_addr), 32'h10);
        check("fi_pc", 32'(ifu_pc), 32'h11);
        check("fi_req", 32'(mem_bus.mem_req), 32'h1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'h0F0F;
        tick();
        mem_bus.mem_ack = 1'b0;
        check_ir("fi_ir", 16'h0F0F);
        tick();

        // mid-fetch reset, late ack ignored
        ifu_ins_load = 1'b1;
        tick();
        ifu_ins_load = 1'b0;
        check("mr_req_pre", 32'(mem_bus.mem_req), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_req_rst", 32'(mem_bus.mem_req), 32'h0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'hFFFF;
        tick();
        mem_bus.mem_ack = 1'b0;
        check_ir("mr_ir", 16'h0000);
        check("mr_valid", 32'(ifu_valid), 32'h0);
        check("mr_req", 32'(mem_bus.mem_req), 32'h0);
        check("mr_pc", 32'(ifu_pc), 32'h00);

`ifdef IFU_FETCH_TIMEOUT_EN
        // load a nonzero IR so the timeout NOP is visible
        ifu_ins_load = 1'b1;
        tick();
        ifu_ins_load      = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'h7777;
        tick();
        mem_bus.mem_ack = 1'b0;
        check_ir("to_pre_ir", 16'h7777);

        // no ack: 16 REQ cycles, then NOP + fault
        ifu_ins_load = 1'b1;
        tick();
        ifu_ins_load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("to_wait_req", 32'(mem_bus.mem_req), 32'h1);
            tick();
        end
        check("to_last_req", 32'(mem_bus.mem_req), 32'h1);
        check("to_nofault_yet", 32'(ifu_fault), 32'h0);
        tick();
        check("to_valid", 32'(ifu_valid), 32'h1);
        check_ir("to_ir_nop", 16'h0000);
        check("to_fault", 32'(ifu_fault), 32'h1);
        check("to_req_drop", 32'(mem_bus.mem_req), 32'h0);
        tick();
        check("to_valid_pulse", 32'(ifu_valid), 32'h0);
        check("to_fault_sticky", 32'(ifu_fault), 32'h1);

        // next fetch still works, fault stays set
        ifu_ins_load = 1'b1;
        tick();
        ifu_ins_load      = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'h2468;
        tick();
        mem_bus.mem_ack = 1'b0;
        check_ir("to_next_ir", 16'h2468);
        check("to_next_fault", 32'(ifu_fault), 32'h1);

        // ack on the count-15 cycle wins
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to2_fault_clr", 32'(ifu_fault), 32'h0);
        ifu_ins_load = 1'b1;
        tick();
        ifu_ins_load = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("to2_req", 32'(mem_bus.mem_req), 32'h1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'h9ABC;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("to2_valid", 32'(ifu_valid), 32'h1);
        check_ir("to2_ir", 16'h9ABC);
        check("to2_fault", 32'(ifu_fault), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
